// File: rtl/ff_pkg.sv
// ff_pkg: shared constants and types for the feed-forward stream loader.
//   - Marker words that delimit the sections of a burst on the engine bus.
//   - Replacement words the sanitiser writes in place of payload words that
//     would otherwise alias a marker.
//   - Loader state and burst section encodings.
package ff_pkg;

   localparam logic [31:0] MARK_BIAS   = 32'h8000_0000;
   localparam logic [31:0] MARK_NEURON = 32'hFFFF_FFFF;
   localparam logic [31:0] MARK_END    = 32'hFFFF_FFF0;
   localparam logic [31:0] POS_ZERO    = 32'h0000_0000;
   localparam logic [31:0] QNAN        = 32'h7FC0_0000;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FILL      = 3'd1,
      ST_LOAD      = 3'd2,
      ST_STREAM    = 3'd3,
      ST_START     = 3'd4,
      ST_WAIT_DONE = 3'd5
   } state_t;

   // Burst sections in emission order; SEC_DONE means every word is issued.
   typedef enum logic [2:0] {
      SEC_W    = 3'd0,
      SEC_MB   = 3'd1,
      SEC_B    = 3'd2,
      SEC_MN   = 3'd3,
      SEC_I    = 3'd4,
      SEC_ME   = 3'd5,
      SEC_DONE = 3'd6
   } sec_t;

   typedef struct packed {
      logic        hit;
      logic [31:0] data;
   } san_t;

   // Rewrites payload words that collide with a marker value.
   function automatic san_t sanitize(input logic [31:0] w);
      san_t r;
      r.hit  = 1'b0;
      r.data = w;
      case (w)
         MARK_BIAS: begin
            r.hit  = 1'b1;
            r.data = POS_ZERO;
         end
         MARK_NEURON, MARK_END: begin
            r.hit  = 1'b1;
            r.data = QNAN;
         end
         default: ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/ff_stream_buf.sv
// ff_stream_buf: DEPTH x 32 simple dual-port RAM for the loader payload.
//   clk      : clock
//   wr_en    : write strobe, wr_addr/wr_data written on the clock edge
//   rd_en    : read strobe, mem[rd_addr] appears on rd_data one cycle later
//   rd_data  : registered read data (holds between reads)
// The array is deliberately not reset so it maps onto block RAM.
module ff_stream_buf
   import ff_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [31:0]       rd_data
);

   logic [31:0] mem [DEPTH];
   logic [31:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/ff_stream_loader.sv
// ff_stream_loader: buffers one job image from a valid/ready source and
// replays it to the feed-forward engine as a gapless, marker-delimited burst.
//   cfg_*     : job configuration handshake (counts and layer sizes)
//   s_*       : payload stream in (accepted only while filling)
//   ff_*      : engine load port (data bus, load/start pulses, layer sizes,
//               done flag in)
//   busy      : job in progress
//   done      : one-cycle pulse when the engine reports completion
//   err_len   : one-cycle pulse when a config does not fit the buffer
//   sanitized : set for the current job once any payload word was rewritten
//
// state        | meaning
// ST_IDLE      | waiting for a job configuration
// ST_FILL      | collecting T payload words into the buffer
// ST_LOAD      | ff_load pulse, first buffer read issued
// ST_STREAM    | burst words leaving on ff_data, one per cycle
// ST_START     | ff_start pulse
// ST_WAIT_DONE | waiting for a fresh rising edge on ff_done
module ff_stream_loader
   import ff_pkg::*;
#(
   parameter int BUF_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ADDR_W-1:0] cfg_n_weight,
   input  logic [ADDR_W-1:0] cfg_n_bias,
   input  logic [ADDR_W-1:0] cfg_n_input,
   input  logic [11:0]       cfg_layers,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [31:0]       s_data,
   output logic [31:0]       ff_data,
   output logic              ff_load,
   output logic              ff_start,
   output logic [2:0]        ff_first_layer,
   output logic [2:0]        ff_second_layer,
   output logic [2:0]        ff_third_layer,
   output logic [2:0]        ff_fourth_layer,
   input  logic              ff_done,
   output logic              busy,
   output logic              done,
   output logic              err_len,
   output logic              sanitized
);

   state_t            state_q, state_d;
   sec_t              sec_q, sec_d;
   logic [ADDR_W-1:0] n_bias_q, n_bias_d;
   logic [ADDR_W-1:0] n_input_q, n_input_d;
   logic [11:0]       layers_q, layers_d;
   logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic              ram_sel_q, ram_sel_d;
   logic [31:0]       mark_q, mark_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              san_q, san_d;
   logic              ff_done_q;

   logic [ADDR_W+1:0] tot;
   san_t              san;
   logic              issue_en;
   logic              buf_wr_en;
   logic              buf_rd_en;
   logic [31:0]       buf_rd_data;

   ff_stream_buf #(
      .DEPTH  (BUF_DEPTH),
      .ADDR_W (ADDR_W)
   ) u_buf (
      .clk     (clk),
      .wr_en   (buf_wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (san.data),
      .rd_en   (buf_rd_en),
      .rd_addr (rd_ptr_q),
      .rd_data (buf_rd_data)
   );

   always_comb begin
      state_d    = state_q;
      sec_d      = sec_q;
      n_bias_d   = n_bias_q;
      n_input_d  = n_input_q;
      layers_d   = layers_q;
      fill_cnt_d = fill_cnt_q;
      cnt_d      = cnt_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      ram_sel_d  = 1'b0;
      mark_d     = POS_ZERO;
      done_d     = 1'b0;
      err_d      = 1'b0;
      san_d      = san_q;
      buf_wr_en  = 1'b0;
      buf_rd_en  = 1'b0;
      san        = sanitize(s_data);
      tot        = {2'b00, cfg_n_weight} + {2'b00, cfg_n_bias} + {2'b00, cfg_n_input};

      case (state_q)
         ST_IDLE: begin
            if (cfg_valid) begin
               layers_d   = cfg_layers;
               n_bias_d   = cfg_n_bias;
               n_input_d  = cfg_n_input;
               fill_cnt_d = tot[ADDR_W-1:0];
               cnt_d      = cfg_n_weight;
               sec_d      = (cfg_n_weight == '0) ? SEC_MB : SEC_W;
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               san_d      = 1'b0;
               if (int'(tot) + 3 > BUF_DEPTH) err_d = 1'b1;
               else if (tot == '0)            state_d = ST_LOAD;
               else                           state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (s_valid) begin
               buf_wr_en  = 1'b1;
               wr_ptr_d   = wr_ptr_q + ADDR_W'(1);
               fill_cnt_d = fill_cnt_q - ADDR_W'(1);
               if (san.hit) san_d = 1'b1;
               if (fill_cnt_q == ADDR_W'(1)) state_d = ST_LOAD;
            end
         end
         ST_LOAD:   state_d = ST_STREAM;
         ST_STREAM: if (sec_q == SEC_DONE) state_d = ST_START;
         ST_START:  state_d = ST_WAIT_DONE;
         ST_WAIT_DONE: begin
            if (ff_done && !ff_done_q) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Word k of the burst is issued in cycle L+k and lands on ff_data one
      // cycle later, either from the RAM read register or from mark_q.
      issue_en = (state_q == ST_LOAD) || (state_q == ST_STREAM && sec_q != SEC_DONE);
      if (issue_en) begin
         case (sec_q)
            SEC_W, SEC_B, SEC_I: begin
               buf_rd_en = 1'b1;
               ram_sel_d = 1'b1;
               rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
               cnt_d     = cnt_q - ADDR_W'(1);
               if (cnt_q == ADDR_W'(1)) begin
                  case (sec_q)
                     SEC_W:   sec_d = SEC_MB;
                     SEC_B:   sec_d = SEC_MN;
                     default: sec_d = SEC_ME;
                  endcase
               end
            end
            // Empty payload sections are skipped so markers can sit back to back.
            SEC_MB: begin
               mark_d = MARK_BIAS;
               cnt_d  = n_bias_q;
               sec_d  = (n_bias_q == '0) ? SEC_MN : SEC_B;
            end
            SEC_MN: begin
               mark_d = MARK_NEURON;
               cnt_d  = n_input_q;
               sec_d  = (n_input_q == '0) ? SEC_ME : SEC_I;
            end
            SEC_ME: begin
               mark_d = MARK_END;
               sec_d  = SEC_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sec_q      <= SEC_W;
         n_bias_q   <= '0;
         n_input_q  <= '0;
         layers_q   <= '0;
         fill_cnt_q <= '0;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         ram_sel_q  <= 1'b0;
         mark_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         san_q      <= 1'b0;
         ff_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         sec_q      <= sec_d;
         n_bias_q   <= n_bias_d;
         n_input_q  <= n_input_d;
         layers_q   <= layers_d;
         fill_cnt_q <= fill_cnt_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         ram_sel_q  <= ram_sel_d;
         mark_q     <= mark_d;
         done_q     <= done_d;
         err_q      <= err_d;
         san_q      <= san_d;
         ff_done_q  <= ff_done;
      end
   end

   // Both mux legs and the select are registered; mark_q is zero outside the
   // burst, so the bus idles at zero.
   assign ff_data         = ram_sel_q ? buf_rd_data : mark_q;
   assign cfg_ready       = (state_q == ST_IDLE);
   assign s_ready         = (state_q == ST_FILL);
   assign busy            = (state_q != ST_IDLE);
   assign ff_load         = (state_q == ST_LOAD);
   assign ff_start        = (state_q == ST_START);
   assign ff_first_layer  = layers_q[2:0];
   assign ff_second_layer = layers_q[5:3];
   assign ff_third_layer  = layers_q[8:6];
   assign ff_fourth_layer = layers_q[11:9];
   assign done            = done_q;
   assign err_len         = err_q;
   assign sanitized       = san_q;

endmodule

// File: tb/tb_ff_stream_loader.sv
module tb_ff_stream_loader;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [7:0]  cfg_n_weight = '0;
   logic [7:0]  cfg_n_bias = '0;
   logic [7:0]  cfg_n_input = '0;
   logic [11:0] cfg_layers = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] s_data = '0;
   logic [31:0] ff_data;
   logic        ff_load, ff_start;
   logic [2:0]  ff_first_layer, ff_second_layer, ff_third_layer, ff_fourth_layer;
   logic        ff_done = 1'b0;
   logic        busy, done, err_len, sanitized;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      int          w;
      int          b;
      int          i;
      logic [11:0] layers;
      bit          gap;
      bit          special;
      bit          exp_err;
      bit          hold_done;
      int          abort_k;
      int          exp_fill;
   } vec_t;

   vec_t vecs[9];

   always #5 clk = ~clk;

   ff_stream_loader dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_valid       (cfg_valid),
      .cfg_ready       (cfg_ready),
      .cfg_n_weight    (cfg_n_weight),
      .cfg_n_bias      (cfg_n_bias),
      .cfg_n_input     (cfg_n_input),
      .cfg_layers      (cfg_layers),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .s_data          (s_data),
      .ff_data         (ff_data),
      .ff_load         (ff_load),
      .ff_start        (ff_start),
      .ff_first_layer  (ff_first_layer),
      .ff_second_layer (ff_second_layer),
      .ff_third_layer  (ff_third_layer),
      .ff_fourth_layer (ff_fourth_layer),
      .ff_done         (ff_done),
      .busy            (busy),
      .done            (done),
      .err_len         (err_len),
      .sanitized       (sanitized)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic logic [31:0] san_model(input logic [31:0] w);
      if (w == 32'h8000_0000) return 32'h0000_0000;
      if (w == 32'hFFFF_FFFF || w == 32'hFFFF_FFF0) return 32'h7FC0_0000;
      return w;
   endfunction

   task automatic run_job(input vec_t v, input int vi);
      logic [31:0] pay[16];
      logic [31:0] exp_w;
      int t, idx, fill, cyc;
      t = v.w + v.b + v.i;
      for (int j = 0; j < 16; j++) pay[j] = 32'h3F80_0000 + 32'(vi << 8) + 32'(j);
      if (v.special) begin
         pay[0] = 32'h8000_0000;
         pay[1] = 32'hFFFF_FFFF;
         pay[2] = 32'hFFFF_FFF0;
      end

      if (!v.exp_err) begin
         for (int j = 0; j < v.w; j++) exp_q.push_back(san_model(pay[j]));
         exp_q.push_back(32'h8000_0000);
         for (int j = 0; j < v.b; j++) exp_q.push_back(san_model(pay[v.w + j]));
         exp_q.push_back(32'hFFFF_FFFF);
         for (int j = 0; j < v.i; j++) exp_q.push_back(san_model(pay[v.w + v.b + j]));
         exp_q.push_back(32'hFFFF_FFF0);
      end

      cfg_n_weight = 8'(v.w);
      cfg_n_bias   = 8'(v.b);
      cfg_n_input  = 8'(v.i);
      cfg_layers   = v.layers;
      cfg_valid    = 1'b1;
      ff_done      = v.hold_done;
      @(negedge clk);
      cfg_valid = 1'b0;
      chk1("err_len_after_cfg", err_len, v.exp_err);
      if (v.exp_err) begin
         chk1("err_busy", busy, 1'b0);
         chk1("err_s_ready", s_ready, 1'b0);
         @(negedge clk);
         chk1("err_len_one_cycle", err_len, 1'b0);
         chk1("err_busy_after", busy, 1'b0);
         chk1("err_s_ready_after", s_ready, 1'b0);
         return;
      end
      chk1("busy_after_cfg", busy, 1'b1);
      chk("layers", {20'h0, ff_fourth_layer, ff_third_layer, ff_second_layer, ff_first_layer},
          {20'h0, v.layers});
      chk1("sanitized_cleared", sanitized, 1'b0);

      idx = 0; fill = 0; cyc = 0;
      while (!ff_load && cyc < 64) begin
         if (s_ready) begin
            s_valid = (v.gap ? (fill % 2 == 1) : 1'b1) && (idx < 16);
            if (s_valid) begin
               s_data = pay[idx];
               idx++;
            end
            fill++;
         end else begin
            s_valid = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      s_valid = 1'b0;
      chk1("load_seen", ff_load, 1'b1);
      if (!ff_load) begin
         exp_q.delete();
         return;
      end
      chk("fill_cycles", 32'(fill), 32'(v.exp_fill));
      chk("data_idle_at_load", ff_data, 32'h0);

      for (int k = 0; k < t + 3; k++) begin
         @(negedge clk);
         exp_w = exp_q.pop_front();
         chk("burst_word", ff_data, exp_w);
         chk1("no_load_in_burst", ff_load, 1'b0);
         chk1("no_start_in_burst", ff_start, 1'b0);
         if (k == v.abort_k) begin
            rst = 1'b1;
            #1;
            chk1("rst_busy", busy, 1'b0);
            chk1("rst_cfg_ready", cfg_ready, 1'b1);
            chk1("rst_s_ready", s_ready, 1'b0);
            chk("rst_ff_data", ff_data, 32'h0);
            chk1("rst_ff_start", ff_start, 1'b0);
            chk1("rst_sanitized", sanitized, 1'b0);
            chk("rst_layers", {20'h0, ff_fourth_layer, ff_third_layer, ff_second_layer, ff_first_layer}, 32'h0);
            @(negedge clk);
            rst = 1'b0;
            exp_q.delete();
            return;
         end
      end
      @(negedge clk);
      chk1("start_pulse", ff_start, 1'b1);
      chk("data_idle_at_start", ff_data, 32'h0);
      chk1("sanitized_flag", sanitized, v.special);
      @(negedge clk);
      chk1("start_one_cycle", ff_start, 1'b0);
      chk1("wait_busy", busy, 1'b1);
      chk1("no_early_done", done, 1'b0);

      if (v.hold_done) begin
         repeat (3) begin
            @(negedge clk);
            chk1("held_done_ignored", done, 1'b0);
         end
         ff_done = 1'b0;
         @(negedge clk);
         chk1("done_after_fall", done, 1'b0);
         chk1("still_busy", busy, 1'b1);
      end
      ff_done = 1'b1;
      @(negedge clk);
      chk1("done_pulse", done, 1'b1);
      chk1("idle_after_done", busy, 1'b0);
      ff_done = 1'b0;
      @(negedge clk);
      chk1("done_one_cycle", done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      //            w    b   i  layers   gap spc err hold abort fill
      vecs[0] = '{  4,   2,  3, 12'h013, 0,  0,  0,  0,   -1,   9 };
      vecs[1] = '{  4,   2,  3, 12'h013, 1,  0,  0,  0,   -1,  18 };
      vecs[2] = '{  2,   0,  0, 12'h0A5, 0,  0,  0,  0,   -1,   2 };
      vecs[3] = '{  2,   1,  1, 12'hFFF, 0,  1,  0,  0,   -1,   4 };
      vecs[4] = '{200,  50,  4, 12'h123, 0,  0,  1,  0,   -1,   0 };
      vecs[5] = '{  0,   0,  0, 12'h249, 0,  0,  0,  0,   -1,   0 };
      vecs[6] = '{  4,   2,  3, 12'h013, 0,  0,  0,  0,    4,   9 };
      vecs[7] = '{  1,   1,  1, 12'h6DB, 0,  0,  0,  0,   -1,   3 };
      vecs[8] = '{  3,   0,  2, 12'h111, 0,  0,  0,  1,   -1,   5 };

      s_valid = 1'b1;
      repeat (2) @(negedge clk);
      chk1("reset_cfg_ready", cfg_ready, 1'b1);
      chk1("reset_s_ready", s_ready, 1'b0);
      chk("reset_ff_data", ff_data, 32'h0);
      chk1("reset_ff_load", ff_load, 1'b0);
      chk1("reset_ff_start", ff_start, 1'b0);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk1("reset_err_len", err_len, 1'b0);
      chk1("reset_sanitized", sanitized, 1'b0);
      chk("reset_layers", {20'h0, ff_fourth_layer, ff_third_layer, ff_second_layer, ff_first_layer}, 32'h0);
      rst = 1'b0;
      @(negedge clk);
      chk1("s_valid_outside_fill", s_ready, 1'b0);
      s_valid = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 9; n++) begin
         run_job(vecs[n], n);
         @(negedge clk);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
